// File: rtl/xilinx_pcie_slot.sv
// Bus-functional PCIe slot: host-side single-dword requests become RX TLPs for
// the endpoint, and TX TLPs from the endpoint are decoded into completions and writes.
module xilinx_pcie_slot #(
  parameter logic [15:0] dev_id        = 16'h5555,
  parameter logic [15:0] ven_id        = 16'haaaa,
  parameter logic [15:0] subsys_id     = 16'h1111,
  parameter logic [15:0] subsys_ven_id = 16'hbbbb,
  parameter logic [31:0] bar_0         = 32'hFFFFF004,
  parameter logic [31:0] bar_1         = 32'hFFFFFFFF,
  parameter int unsigned RST_CYCLES    = 4
) (
  input  logic        user_clk,
  input  logic        user_reset_n,
  output logic        user_clk_out,
  output logic        user_reset_out,
  output logic        tx_cfg_req,
  input  logic        tx_cfg_gnt,
  output logic [63:0] m_axis_rx_tdata,
  output logic [7:0]  m_axis_rx_tkeep,
  output logic        m_axis_rx_tlast,
  output logic        m_axis_rx_tvalid,
  output logic [21:0] m_axis_rx_tuser,
  input  logic        m_axis_rx_tready,
  input  logic [63:0] s_axis_tx_tdata,
  input  logic [7:0]  s_axis_tx_tkeep,
  input  logic        s_axis_tx_tlast,
  input  logic        s_axis_tx_tvalid,
  input  logic [3:0]  s_axis_tx_tuser,
  output logic        s_axis_tx_tready,
  input  logic        cfg_interrupt,
  output logic        cfg_interrupt_rdy,
  input  logic        cfg_interrupt_assert,
  input  logic [7:0]  cfg_interrupt_di,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic [1:0]  host_req_type,
  input  logic [31:0] host_req_addr,
  input  logic [31:0] host_req_wdata,
  output logic        host_rsp_valid,
  output logic [31:0] host_rsp_data,
  output logic        host_wr_valid,
  output logic [63:0] host_wr_addr,
  output logic [31:0] host_wr_data,
  output logic        host_inta
);

  typedef enum logic [2:0] {H_IDLE, H_CFG, H_RX0, H_RX1, H_RDWAIT} hst_e;
  typedef enum logic [1:0] {T_COLLECT, T_DECODE, T_DRAIN} tx_e;

  // A 64-bit BAR0 turns BAR1 into its upper address half: no type bits there.
  localparam logic [31:0] M0 = {bar_0[31:4], 4'h0};
  localparam logic [31:0] M1 = (bar_0[2:1] == 2'b10) ? bar_1 : {bar_1[31:4], 4'h0};
  localparam logic [3:0]  T1 = (bar_0[2:1] == 2'b10) ? 4'h0 : bar_1[3:0];

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  logic [1:0]  rsync_q;
  logic        rst_out_q;
  logic [7:0]  rcnt_q;
  logic        run;

  hst_e        hst_q, hst_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] bar0_q, bar0_d, bar1_q, bar1_d;
  logic [7:0]  tag_q, tag_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d, cfg_rdata;
  logic        bar0_hit, cpl_hit;

  tx_e         tx_q, tx_d;
  logic [31:0] tbuf_q [64];
  logic [6:0]  cnt_q, cnt_d, hi_pos;
  logic [7:0]  cnt_sum;
  logic        lo, hi, tx_fire, is_mwr;
  logic [10:0] wr_idx_q, wr_idx_d, wr_len_q, wr_len_d;
  logic [2:0]  wr_start_q, wr_start_d;
  logic [11:0] rd_pos;
  logic [63:0] wr_base_q, wr_base_d, wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_valid_q, wr_valid_d;
  logic        irq_rdy_q, inta_q;
  logic        unused_ok;

  assign unused_ok      = ^{cfg_interrupt_di, s_axis_tx_tuser};
  assign user_clk_out   = user_clk;
  assign user_reset_out = rst_out_q;
  assign run            = ~rst_out_q;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      rsync_q   <= '0;
      rst_out_q <= 1'b1;
      rcnt_q    <= '0;
    end else begin
      rsync_q <= {rsync_q[0], 1'b1};
      if (rst_out_q && rsync_q[1]) begin
        rcnt_q <= rcnt_q + 8'd1;
        if (rcnt_q == 8'(RST_CYCLES - 1)) rst_out_q <= 1'b0;
      end
    end
  end

  assign bar0_hit = (((host_req_addr ^ bar0_q) & M0) == '0) && (bar0_q != '0);

  always_comb begin
    case (addr_q[11:0])
      12'h000: cfg_rdata = {dev_id, ven_id};
      12'h010: cfg_rdata = bar0_q | {28'h0, bar_0[3:0]};
      12'h014: cfg_rdata = bar1_q | {28'h0, T1};
      12'h02C: cfg_rdata = {subsys_id, subsys_ven_id};
      default: cfg_rdata = '0;
    endcase
  end

  always_comb begin
    hst_d = hst_q; type_d = type_q; addr_d = addr_q; wdata_d = wdata_q;
    bar0_d = bar0_q; bar1_d = bar1_q; tag_d = tag_q;
    rsp_valid_d = 1'b0; rsp_data_d = rsp_data_q;
    host_req_ready = 1'b0; tx_cfg_req = 1'b0;
    m_axis_rx_tdata = '0; m_axis_rx_tkeep = '0; m_axis_rx_tlast = 1'b0;
    m_axis_rx_tvalid = 1'b0; m_axis_rx_tuser = '0;
    case (hst_q)
      H_IDLE: begin
        host_req_ready = run;
        if (run && host_req_valid) begin
          type_d = host_req_type; addr_d = host_req_addr; wdata_d = host_req_wdata;
          if (host_req_type[1]) hst_d = H_CFG;
          else if (bar0_hit) hst_d = H_RX0;
          else if (host_req_type == 2'b00) begin
            rsp_valid_d = 1'b1; rsp_data_d = '1;
          end
        end
      end
      H_CFG: begin
        tx_cfg_req = 1'b1;
        if (tx_cfg_gnt) begin
          hst_d = H_IDLE;
          if (type_q == 2'b11) begin
            if (addr_q[11:0] == 12'h010) bar0_d = wdata_q & M0;
            if (addr_q[11:0] == 12'h014) bar1_d = wdata_q & M1;
          end else begin
            rsp_valid_d = 1'b1; rsp_data_d = cfg_rdata;
          end
        end
      end
      H_RX0: begin
        m_axis_rx_tvalid = 1'b1; m_axis_rx_tkeep = 8'hFF; m_axis_rx_tuser = 22'h000004;
        m_axis_rx_tdata = {16'h0, tag_q, 8'h0F, type_q[0] ? 32'h40000001 : 32'h00000001};
        if (m_axis_rx_tready) hst_d = H_RX1;
      end
      H_RX1: begin
        m_axis_rx_tvalid = 1'b1; m_axis_rx_tlast = 1'b1; m_axis_rx_tuser = 22'h000004;
        m_axis_rx_tkeep = type_q[0] ? 8'hFF : 8'h0F;
        m_axis_rx_tdata = {type_q[0] ? bswap(wdata_q) : 32'h0, addr_q};
        if (m_axis_rx_tready) hst_d = type_q[0] ? H_IDLE : H_RDWAIT;
      end
      H_RDWAIT: begin
        if (cpl_hit) begin
          rsp_valid_d = 1'b1; rsp_data_d = bswap(tbuf_q[3]);
          tag_d = tag_q + 8'd1; hst_d = H_IDLE;
        end
      end
      default: hst_d = H_IDLE;
    endcase
  end

  assign s_axis_tx_tready = run && (tx_q == T_COLLECT) && !(tx_cfg_req && !tx_cfg_gnt);
  assign tx_fire = s_axis_tx_tvalid && s_axis_tx_tready;
  assign lo      = |s_axis_tx_tkeep[3:0];
  assign hi      = |s_axis_tx_tkeep[7:4];
  assign hi_pos  = cnt_q + {6'b0, lo};
  assign cnt_sum = {1'b0, cnt_q} + {7'b0, lo} + {7'b0, hi};
  assign is_mwr  = (tbuf_q[0][31:24] == 8'h40 || tbuf_q[0][31:24] == 8'h60) && cnt_q >= 7'd3;
  assign cpl_hit = (tx_q == T_DECODE) && (tbuf_q[0][31:24] == 8'h4A) && cnt_q >= 7'd4 &&
                   (hst_q == H_RDWAIT) && (tbuf_q[2][15:8] == tag_q);
  assign rd_pos  = 12'(wr_start_q) + 12'(wr_idx_q);

  // Beat DWs are stored per tkeep nibble; anything past 64 DW falls off the end.
  always_ff @(posedge user_clk) begin
    if (tx_fire) begin
      if (lo && !cnt_q[6]) tbuf_q[cnt_q[5:0]] <= s_axis_tx_tdata[31:0];
      if (hi && !hi_pos[6]) tbuf_q[hi_pos[5:0]] <= s_axis_tx_tdata[63:32];
    end
  end

  always_comb begin
    tx_d = tx_q; cnt_d = cnt_q;
    wr_idx_d = wr_idx_q; wr_len_d = wr_len_q; wr_start_d = wr_start_q; wr_base_d = wr_base_q;
    wr_valid_d = 1'b0; wr_addr_d = wr_addr_q; wr_data_d = wr_data_q;
    case (tx_q)
      T_COLLECT: begin
        if (tx_fire) begin
          cnt_d = (cnt_sum > 8'd64) ? 7'd64 : cnt_sum[6:0];
          if (s_axis_tx_tlast) tx_d = T_DECODE;
        end
      end
      T_DECODE: begin
        tx_d = T_COLLECT; cnt_d = '0;
        if (is_mwr) begin
          tx_d = T_DRAIN; cnt_d = cnt_q; wr_idx_d = '0;
          wr_len_d   = (tbuf_q[0][9:0] == 10'd0) ? 11'd1024 : {1'b0, tbuf_q[0][9:0]};
          wr_start_d = tbuf_q[0][29] ? 3'd4 : 3'd3;
          wr_base_d  = tbuf_q[0][29] ? {tbuf_q[2], tbuf_q[3]} : {32'h0, tbuf_q[2]};
        end
      end
      T_DRAIN: begin
        // Stop at the declared length or at the last DW actually captured.
        if (wr_idx_q < wr_len_q && rd_pos < 12'(cnt_q)) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = wr_base_q + {51'h0, wr_idx_q, 2'b00};
          wr_data_d  = bswap(tbuf_q[rd_pos[5:0]]);
          wr_idx_d   = wr_idx_q + 11'd1;
        end else begin
          tx_d = T_COLLECT; cnt_d = '0;
        end
      end
      default: tx_d = T_COLLECT;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      hst_q <= H_IDLE; type_q <= '0; addr_q <= '0; wdata_q <= '0;
      bar0_q <= '0; bar1_q <= '0; tag_q <= '0;
      rsp_valid_q <= 1'b0; rsp_data_q <= '0;
      tx_q <= T_COLLECT; cnt_q <= '0;
      wr_idx_q <= '0; wr_len_q <= '0; wr_start_q <= '0; wr_base_q <= '0;
      wr_valid_q <= 1'b0; wr_addr_q <= '0; wr_data_q <= '0;
      irq_rdy_q <= 1'b0; inta_q <= 1'b0;
    end else if (run) begin
      hst_q <= hst_d; type_q <= type_d; addr_q <= addr_d; wdata_q <= wdata_d;
      bar0_q <= bar0_d; bar1_q <= bar1_d; tag_q <= tag_d;
      rsp_valid_q <= rsp_valid_d; rsp_data_q <= rsp_data_d;
      tx_q <= tx_d; cnt_q <= cnt_d;
      wr_idx_q <= wr_idx_d; wr_len_q <= wr_len_d; wr_start_q <= wr_start_d; wr_base_q <= wr_base_d;
      wr_valid_q <= wr_valid_d; wr_addr_q <= wr_addr_d; wr_data_q <= wr_data_d;
      if (cfg_interrupt && !irq_rdy_q) begin
        irq_rdy_q <= 1'b1;
        inta_q    <= cfg_interrupt_assert;
      end else begin
        irq_rdy_q <= 1'b0;
      end
    end
  end

  assign host_rsp_valid    = rsp_valid_q;
  assign host_rsp_data     = rsp_data_q;
  assign host_wr_valid     = wr_valid_q;
  assign host_wr_addr      = wr_addr_q;
  assign host_wr_data      = wr_data_q;
  assign cfg_interrupt_rdy = irq_rdy_q;
  assign host_inta         = inta_q;

endmodule

// File: tb/tb_xilinx_pcie_slot.sv
// Directed bench for xilinx_pcie_slot: a table of host requests with expected
// responses, plus hand-written RX/TX TLP, interrupt and reset sequences.
module tb_xilinx_pcie_slot;

  logic        user_clk = 1'b0;
  logic        user_reset_n = 1'b1;
  logic        user_clk_out, user_reset_out;
  logic        tx_cfg_req, tx_cfg_gnt;
  logic [63:0] m_axis_rx_tdata;
  logic [7:0]  m_axis_rx_tkeep;
  logic        m_axis_rx_tlast, m_axis_rx_tvalid, m_axis_rx_tready;
  logic [21:0] m_axis_rx_tuser;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tready;
  logic [3:0]  s_axis_tx_tuser;
  logic        cfg_interrupt, cfg_interrupt_rdy, cfg_interrupt_assert;
  logic [7:0]  cfg_interrupt_di;
  logic        host_req_valid, host_req_ready;
  logic [1:0]  host_req_type;
  logic [31:0] host_req_addr, host_req_wdata;
  logic        host_rsp_valid;
  logic [31:0] host_rsp_data;
  logic        host_wr_valid;
  logic [63:0] host_wr_addr;
  logic [31:0] host_wr_data;
  logic        host_inta;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] txq [$];

  xilinx_pcie_slot #(.dev_id(16'h5555), .ven_id(16'haaaa), .subsys_id(16'h1111),
                     .subsys_ven_id(16'hbbbb), .bar_0(32'hFFFFF004), .bar_1(32'hFFFFFFFF),
                     .RST_CYCLES(4)) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .user_clk_out(user_clk_out),
    .user_reset_out(user_reset_out), .tx_cfg_req(tx_cfg_req), .tx_cfg_gnt(tx_cfg_gnt),
    .m_axis_rx_tdata(m_axis_rx_tdata), .m_axis_rx_tkeep(m_axis_rx_tkeep),
    .m_axis_rx_tlast(m_axis_rx_tlast), .m_axis_rx_tvalid(m_axis_rx_tvalid),
    .m_axis_rx_tuser(m_axis_rx_tuser), .m_axis_rx_tready(m_axis_rx_tready),
    .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
    .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
    .s_axis_tx_tuser(s_axis_tx_tuser), .s_axis_tx_tready(s_axis_tx_tready),
    .cfg_interrupt(cfg_interrupt), .cfg_interrupt_rdy(cfg_interrupt_rdy),
    .cfg_interrupt_assert(cfg_interrupt_assert), .cfg_interrupt_di(cfg_interrupt_di),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_type(host_req_type), .host_req_addr(host_req_addr),
    .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
    .host_rsp_data(host_rsp_data), .host_wr_valid(host_wr_valid),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_inta(host_inta));

  always #5 user_clk = ~user_clk;

  // Config grant arrives on the third clock of a request, changed just after posedge.
  initial begin
    int gcnt;
    gcnt = 0; tx_cfg_gnt = 1'b0;
    forever begin
      @(posedge user_clk); #2;
      if (tx_cfg_req) begin gcnt++; tx_cfg_gnt = (gcnt == 3); end
      else begin gcnt = 0; tx_cfg_gnt = 1'b0; end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic host_issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge user_clk);
    while (!host_req_ready && n < 100) begin @(negedge user_clk); n++; end
    check("host_ready", host_req_ready, 1);
    host_req_type = t; host_req_addr = a; host_req_wdata = d; host_req_valid = 1'b1;
    @(posedge user_clk); #1;
    host_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got, output logic [31:0] d);
    got = 1'b0; d = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge user_clk);
      if (host_rsp_valid) begin got = 1'b1; d = host_rsp_data; end
    end
  endtask

  task automatic quiet_window(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge user_clk);
      if (host_rsp_valid || m_axis_rx_tvalid) seen = 1'b1;
    end
  endtask

  task automatic rx_beat(input string nm, input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    n = 0;
    @(negedge user_clk);
    while (!m_axis_rx_tvalid && n < 50) begin @(negedge user_clk); n++; end
    check({nm, "_tvalid"}, m_axis_rx_tvalid, 1);
    check({nm, "_tdata"}, m_axis_rx_tdata, d);
    check({nm, "_tkeep"}, m_axis_rx_tkeep, k);
    check({nm, "_tlast"}, m_axis_rx_tlast, l);
    check({nm, "_tuser"}, m_axis_rx_tuser, 22'h000004);
  endtask

  task automatic send_tlp();
    int n, nb;
    nb = (txq.size() + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      @(negedge user_clk);
      s_axis_tx_tvalid = 1'b1;
      s_axis_tx_tlast  = (b == nb - 1);
      if (2 * b + 1 < txq.size()) begin
        s_axis_tx_tdata = {txq[2*b+1], txq[2*b]}; s_axis_tx_tkeep = 8'hFF;
      end else begin
        s_axis_tx_tdata = {32'h0, txq[2*b]}; s_axis_tx_tkeep = 8'h0F;
      end
      n = 0;
      while (!s_axis_tx_tready && n < 100) begin @(negedge user_clk); n++; end
      if (n >= 100) check("tx_accept", s_axis_tx_tready, 1);
      @(posedge user_clk);
    end
    #1 s_axis_tx_tvalid = 1'b0; s_axis_tx_tlast = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    int n;
    user_reset_n = 1'b0;
    #1;
    check({nm, "_rst_out"}, user_reset_out, 1);
    check({nm, "_outs_idle"}, {m_axis_rx_tvalid, s_axis_tx_tready, host_req_ready, host_rsp_valid,
          host_wr_valid, host_inta, cfg_interrupt_rdy, tx_cfg_req}, 8'h00);
    repeat (10) @(negedge user_clk);
    check({nm, "_rst_hold"}, user_reset_out, 1);
    user_reset_n = 1'b1;
    n = 0;
    while (user_reset_out && n < 30) begin
      @(negedge user_clk); n++;
      if (n == 3) check({nm, "_tready_in_rst"}, s_axis_tx_tready, 0);
    end
    check({nm, "_release_cycles"}, n, 6);
    check({nm, "_ready_after"}, {host_req_ready, s_axis_tx_tready}, 2'b11);
  endtask

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          rsp;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [13];

  initial begin
    bit got, seen;
    logic [31:0] d;
    logic [63:0] wa [$];
    logic [31:0] wd [$];
    logic [63:0] exp_wa [4];
    logic [31:0] exp_wd [4];

    vt[0]  = '{2'b10, 32'h0000_0000, 32'h0, 1'b1, 32'h5555aaaa};
    vt[1]  = '{2'b10, 32'h0000_002C, 32'h0, 1'b1, 32'h1111bbbb};
    vt[2]  = '{2'b10, 32'h0000_0010, 32'h0, 1'b1, 32'h00000004};
    vt[3]  = '{2'b00, 32'h8000_0010, 32'h0, 1'b1, 32'hFFFFFFFF};
    vt[4]  = '{2'b11, 32'h0000_0010, 32'hFFFFFFFF, 1'b0, 32'h0};
    vt[5]  = '{2'b10, 32'h0000_0010, 32'h0, 1'b1, 32'hFFFFF004};
    vt[6]  = '{2'b11, 32'h0000_0014, 32'h12345678, 1'b0, 32'h0};
    vt[7]  = '{2'b10, 32'h0000_0014, 32'h0, 1'b1, 32'h12345678};
    vt[8]  = '{2'b10, 32'h0000_0008, 32'h0, 1'b1, 32'h00000000};
    vt[9]  = '{2'b11, 32'h0000_0010, 32'h80000000, 1'b0, 32'h0};
    vt[10] = '{2'b10, 32'h0000_0010, 32'h0, 1'b1, 32'h80000004};
    vt[11] = '{2'b00, 32'h0000_1000, 32'h0, 1'b1, 32'hFFFFFFFF};
    vt[12] = '{2'b01, 32'h0000_1000, 32'hCAFEF00D, 1'b0, 32'h0};

    host_req_valid = 0; host_req_type = 0; host_req_addr = 0; host_req_wdata = 0;
    s_axis_tx_tdata = 0; s_axis_tx_tkeep = 0; s_axis_tx_tlast = 0; s_axis_tx_tvalid = 0;
    s_axis_tx_tuser = 0; cfg_interrupt = 0; cfg_interrupt_assert = 0; cfg_interrupt_di = 8'h5A;
    m_axis_rx_tready = 1'b1;

    @(negedge user_clk);
    do_reset("init");

    for (int i = 0; i < 13; i++) begin
      host_issue(vt[i].typ, vt[i].addr, vt[i].wdata);
      if (vt[i].typ[1]) begin
        @(negedge user_clk);
        check($sformatf("v%0d_cfg_req", i), {tx_cfg_req, s_axis_tx_tready}, 2'b10);
      end
      if (vt[i].rsp) begin
        wait_rsp(got, d);
        check($sformatf("v%0d_rsp_seen", i), got, 1);
        check($sformatf("v%0d_rsp_data", i), d, vt[i].exp);
      end else begin
        quiet_window(seen);
        check($sformatf("v%0d_quiet", i), seen, 0);
      end
    end

    // Hit write with backpressure on the RX side.
    m_axis_rx_tready = 1'b0;
    host_issue(2'b01, 32'h80000010, 32'h11223344);
    rx_beat("mwr_b1", {32'h0000000F, 32'h40000001}, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge user_clk);
      check("mwr_hold", {m_axis_rx_tvalid, m_axis_rx_tdata}, {1'b1, 32'h0000000F, 32'h40000001});
    end
    check("mwr_busy_not_ready", host_req_ready, 0);
    m_axis_rx_tready = 1'b1;
    rx_beat("mwr_b2", {32'h44332211, 32'h80000010}, 8'hFF, 1'b1);
    @(negedge user_clk);
    check("mwr_done", m_axis_rx_tvalid, 0);

    // Hit read, wrong-tag completion ignored, then the matching one.
    host_issue(2'b00, 32'h80000010, 32'h0);
    rx_beat("mrd_b1", {32'h0000000F, 32'h00000001}, 8'hFF, 1'b0);
    rx_beat("mrd_b2", {32'h00000000, 32'h80000010}, 8'h0F, 1'b1);
    txq = '{32'h4A000001, 32'h0, 32'h00000500, 32'hAABBCCDD};
    send_tlp();
    quiet_window(seen);
    check("cpl_badtag_quiet", {seen, host_req_ready}, 2'b00);
    txq = '{32'h4A000001, 32'h0, 32'h00000000, 32'h44332211};
    send_tlp();
    wait_rsp(got, d);
    check("cpl_rsp_seen", got, 1);
    check("cpl_rsp_data", d, 32'h11223344);

    host_issue(2'b00, 32'h80000010, 32'h0);
    rx_beat("mrd2_b1", {32'h0000010F, 32'h00000001}, 8'hFF, 1'b0);
    rx_beat("mrd2_b2", {32'h00000000, 32'h80000010}, 8'h0F, 1'b1);
    txq = '{32'h4A000001, 32'h0, 32'h00000100, 32'hDDCCBBAA};
    send_tlp();
    wait_rsp(got, d);
    check("cpl2_rsp_data", {got, d}, {1'b1, 32'hAABBCCDD});

    // Device-originated MWr32, 4 DW.
    txq = '{32'h40000004, 32'h0, 32'h00001000,
            32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    send_tlp();
    exp_wa = '{64'h1000, 64'h1004, 64'h1008, 64'h100C};
    exp_wd = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    for (int i = 0; i < 20; i++) begin
      @(negedge user_clk);
      if (host_wr_valid) begin wa.push_back(host_wr_addr); wd.push_back(host_wr_data); end
    end
    check("mwr32_count", wa.size(), 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      check($sformatf("mwr32_addr%0d", i), wa[i], exp_wa[i]);
      check($sformatf("mwr32_data%0d", i), wd[i], exp_wd[i]);
    end

    // Device-originated MWr64, 1 DW.
    wa.delete(); wd.delete();
    txq = '{32'h60000001, 32'h0, 32'h00000001, 32'h00002000, 32'hDEADBEEF};
    send_tlp();
    for (int i = 0; i < 20; i++) begin
      @(negedge user_clk);
      if (host_wr_valid) begin wa.push_back(host_wr_addr); wd.push_back(host_wr_data); end
    end
    check("mwr64_count", wa.size(), 1);
    if (wa.size() > 0) check("mwr64_beat", {wa[0], wd[0]}, {64'h0000_0001_0000_2000, 32'hEFBEADDE});

    // Legacy interrupt handshake: assert, deassert, assert again.
    for (int k = 0; k < 3; k++) begin
      @(negedge user_clk);
      cfg_interrupt = 1'b1; cfg_interrupt_assert = (k != 1);
      @(negedge user_clk);
      check($sformatf("irq%0d_rdy", k), cfg_interrupt_rdy, 1);
      check($sformatf("irq%0d_inta", k), host_inta, (k != 1));
      cfg_interrupt = 1'b0;
      @(negedge user_clk);
      check($sformatf("irq%0d_rdy_pulse", k), {cfg_interrupt_rdy, host_inta}, {1'b0, (k != 1)});
    end

    // Reset in the middle of an outstanding read.
    host_issue(2'b00, 32'h80000010, 32'h0);
    rx_beat("mrd3_b1", {32'h0000020F, 32'h00000001}, 8'hFF, 1'b0);
    rx_beat("mrd3_b2", {32'h00000000, 32'h80000010}, 8'h0F, 1'b1);
    @(negedge user_clk);
    check("mrd3_outstanding", host_req_ready, 0);
    do_reset("mid");
    host_issue(2'b10, 32'h00000010, 32'h0);
    wait_rsp(got, d);
    check("post_rst_bar0", {got, d}, {1'b1, 32'h00000004});
    host_issue(2'b11, 32'h00000010, 32'h80000000);
    host_issue(2'b00, 32'h80000010, 32'h0);
    rx_beat("mrd4_b1", {32'h0000000F, 32'h00000001}, 8'hFF, 1'b0);
    rx_beat("mrd4_b2", {32'h00000000, 32'h80000010}, 8'h0F, 1'b1);
    txq = '{32'h4A000001, 32'h0, 32'h00000000, 32'h78563412};
    send_tlp();
    wait_rsp(got, d);
    check("mrd4_rsp", {got, d}, {1'b1, 32'h12345678});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
